instr_fetch_unit: RTL and testbench

- Instruction-fetch control unit for the 16-bit microcontroller datapath.
- Merges the fetch sequencer (IFFSM) and the program counter (PC) into one block.
- Drives the bus, MAR, memory, MDR and IR enables for each fetch, then waits for the execute stage to report completion before the next fetch.
- Sits between the shared datapath bus/memory interface and the execute controller.

---
 rtl/instr_fetch_unit.sv | 81 ++++++++
 tb/tb_instr_fetch_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer and program counter for the 16-bit datapath.
// Walks PC->MAR, memory read, MDR->IR, then waits for execute completion.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done,
  input  logic                mfc,
  input  logic                pc_inc,
  output logic                pc_out_en,
  output logic                mar_in,
  output logic                mem_en,
  output logic                rw,
  output logic                md_read_en,
  output logic                mdr_out,
  output logic                ir_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PC2MAR = 3'd1,
    MEMRD  = 3'd2,
    MDRLD  = 3'd3,
    MDR2IR = 3'd4,
    EXEC   = 3'd5
  } state_t;

  state_t cur;
  state_t nxt;
  logic   bump;

  always_comb begin
    nxt = IDLE;
    unique case (cur)
      IDLE:    nxt = PC2MAR;
      PC2MAR:  nxt = MEMRD;
      MEMRD:   nxt = mfc ? MDRLD : MEMRD;
      MDRLD:   nxt = MDR2IR;
      MDR2IR:  nxt = EXEC;
      EXEC:    nxt = done ? PC2MAR : EXEC;
      default: nxt = IDLE;
    endcase
  end

  // Both increment sources together still advance the PC by one.
  assign bump = (cur == MDR2IR) |
                (pc_inc & (cur != IDLE));

  // Controls are registered from the next state so they track cur glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= IDLE;
      pc_out     <= RESET_PC;
      pc_out_en  <= 1'b0;
      mar_in     <= 1'b0;
      mem_en     <= 1'b0;
      rw         <= 1'b0;
      md_read_en <= 1'b0;
      mdr_out    <= 1'b0;
      ir_in      <= 1'b0;
    end else begin
      cur        <= nxt;
      if (bump)
        pc_out   <= pc_out + PC_WIDTH'(1);
      pc_out_en  <= (nxt == PC2MAR);
      mar_in     <= (nxt == PC2MAR);
      mem_en     <= (nxt == MEMRD) | (nxt == MDRLD);
      rw         <= (nxt == MEMRD) | (nxt == MDRLD);
      md_read_en <= (nxt == MDRLD);
      mdr_out    <= (nxt == MDR2IR);
      ir_in      <= (nxt == MDR2IR);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit.
// Driver predicts each cycle's outcome; monitor compares after the edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic        mfc = 1'b0;
  logic        pc_inc = 1'b0;
  logic        pc_out_en, mar_in, mem_en, rw;
  logic        md_read_en, mdr_out, ir_in;
  logic [15:0] pc_out;
  logic [2:0]  state;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .done(done), .mfc(mfc), .pc_inc(pc_inc),
    .pc_out_en(pc_out_en), .mar_in(mar_in), .mem_en(mem_en), .rw(rw),
    .md_read_en(md_read_en), .mdr_out(mdr_out), .ir_in(ir_in),
    .pc_out(pc_out), .state(state)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          s;
    logic [6:0]  ctl;
    logic [15:0] pc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errors = 0;
  int          ms = 0;
  logic [15:0] mpc = 16'h0000;

  // {pc_out_en, mar_in, mem_en, rw, md_read_en, mdr_out, ir_in}
  function automatic logic [6:0] ctl_of(int s);
    case (s)
      1:       return 7'b1100000;
      2:       return 7'b0011000;
      3:       return 7'b0011100;
      4:       return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] dut_ctl();
    return {pc_out_en, mar_in, mem_en, rw, md_read_en, mdr_out, ir_in};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(bit r, bit d, bit m, bit p);
    exp_t e;
    @(negedge clk);
    rst = r; done = d; mfc = m; pc_inc = p;
    if (!r) begin
      ms  = 0;
      mpc = 16'h0000;
    end else begin
      if (ms == 4 || (p && ms != 0))
        mpc = mpc + 16'd1;
      case (ms)
        0:       ms = 1;
        1:       ms = 2;
        2:       ms = m ? 3 : 2;
        3:       ms = 4;
        4:       ms = 5;
        5:       ms = d ? 1 : 5;
        default: ms = 0;
      endcase
    end
    e.s = ms;
    e.ctl = ctl_of(ms);
    e.pc = mpc;
    q.push_back(e);
  endtask

  task automatic fetch(bit p_at_ir);
    if (ms == 5)
      step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12 && ms != 5; i++)
      step(1'b1, 1'b0, 1'b1, (ms == 4) ? p_at_ir : 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_ctl", 32'(dut_ctl()), 0);
    chk("async_pc", 32'(pc_out), 0);
    ms  = 0;
    mpc = 16'h0000;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", 32'(state), 32'(e.s));
        chk("ctl", 32'(dut_ctl()), 32'(e.ctl));
        chk("pc", 32'(pc_out), 32'(e.pc));
      end
    end
  end

  initial begin : driver
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    fetch(1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    fetch(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3000)
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    for (int i = 0; i < 20 && ms != 5; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 70000 && mpc != 16'hFFFF; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1);
    fetch(1'b0);
    @(posedge clk);
    #2;
    chk("wrap_pc", 32'(pc_out), 0);
    chk("drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
